// File: rtl/decode_seq.sv
// Streaming ByteDecode_ELL sequencer: unpacks a little-endian byte stream
// into NUM_COEFFS coefficients of ELL bits over valid/ready handshakes.
module decode_seq #(
  parameter int ELL        = 8,
  parameter int NUM_COEFFS = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           in_valid,
  input  logic [7:0]     in_byte,
  output logic           in_ready,
  output logic           out_valid,
  output logic [ELL-1:0] out_coeff,
  output logic [7:0]     out_index,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
);

  localparam int ACC_W  = ELL + 7;
  localparam int NBW    = $clog2(ELL + 8);
  localparam int NBYTES = NUM_COEFFS * ELL / 8;
  localparam int BCW    = $clog2(NBYTES + 1);

  localparam logic [NBW-1:0] ELL_N  = NBW'(ELL);
  localparam logic [BCW-1:0] NB_MAX = BCW'(NBYTES);
  localparam logic [7:0]     LAST   = 8'(NUM_COEFFS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [NBW-1:0]   nbits_q, nbits_d;
  logic [BCW-1:0]   bytes_q, bytes_d;
  logic [7:0]       cnt_q, cnt_d;

  logic run;
  logic take;
  logic give;

  assign run       = (state_q == RUN);
  assign in_ready  = run && (nbits_q < ELL_N) && (bytes_q < NB_MAX);
  assign out_valid = run && (nbits_q >= ELL_N);
  assign take      = in_valid && in_ready;
  assign give      = out_valid && out_ready;
  assign out_coeff = acc_q[ELL-1:0];
  assign out_index = cnt_q;
  assign busy      = run;
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    nbits_d = nbits_q;
    bytes_d = bytes_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        // take and give are mutually exclusive by the nbits split
        if (take) begin
          acc_d   = acc_q | (ACC_W'(in_byte) << nbits_q);
          nbits_d = nbits_q + NBW'(8);
          bytes_d = bytes_q + BCW'(1);
        end
        if (give) begin
          acc_d   = acc_q >> ELL;
          nbits_d = nbits_q - ELL_N;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            bytes_d = '0;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      nbits_d = '0;
      bytes_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      nbits_q <= '0;
      bytes_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nbits_q <= nbits_d;
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_seq.sv
// Directed bench for decode_seq: ELL=8 full decode, ELL=12 vector table,
// ELL=1 bit-serial case, back-pressure, abort and async reset.
module tb_decode_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       start_a, abort_a, in_valid_a, in_ready_a;
  logic       out_valid_a, out_ready_a, busy_a, done_a;
  logic [7:0] in_byte_a, out_coeff_a, out_index_a;

  logic        start_b, abort_b, in_valid_b, in_ready_b;
  logic        out_valid_b, out_ready_b, busy_b, done_b;
  logic [7:0]  in_byte_b, out_index_b;
  logic [11:0] out_coeff_b;

  logic       start_c, abort_c, in_valid_c, in_ready_c;
  logic       out_valid_c, out_ready_c, busy_c, done_c;
  logic [7:0] in_byte_c, out_index_c;
  logic [0:0] out_coeff_c;

  decode_seq #(.ELL(8), .NUM_COEFFS(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .in_valid(in_valid_a), .in_byte(in_byte_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_coeff(out_coeff_a),
    .out_index(out_index_a), .out_ready(out_ready_a),
    .busy(busy_a), .done(done_a));

  decode_seq #(.ELL(12), .NUM_COEFFS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .in_valid(in_valid_b), .in_byte(in_byte_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_coeff(out_coeff_b),
    .out_index(out_index_b), .out_ready(out_ready_b),
    .busy(busy_b), .done(done_b));

  decode_seq #(.ELL(1), .NUM_COEFFS(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
    .in_valid(in_valid_c), .in_byte(in_byte_c), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_coeff(out_coeff_c),
    .out_index(out_index_c), .out_ready(out_ready_c),
    .busy(busy_c), .done(done_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [11:0] c0, c1;
  } vec12_t;

  vec12_t     v12[5];
  logic [7:0] bytes_a[256];
  logic [7:0] got_a[256];
  logic [7:0] gidx_a[256];
  int         overlap_a = 0;
  int         overlap_b = 0;

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic feed_a(input int nbytes, input int stop, output int n);
    int   bi;
    logic tk, hs;
    bi = 0;
    n  = 0;
    for (int cyc = 0; cyc < 2000 && n < stop; cyc++) begin
      in_valid_a  = (bi < nbytes);
      in_byte_a   = (bi < nbytes) ? bytes_a[bi] : 8'h00;
      out_ready_a = 1'b1;
      tk = in_valid_a && in_ready_a;
      hs = out_valid_a;
      if (out_valid_a && in_ready_a) overlap_a++;
      if (hs) begin
        got_a[n]  = out_coeff_a;
        gidx_a[n] = out_index_a;
      end
      @(posedge clk); #1;
      if (tk) bi++;
      if (hs) n++;
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
  endtask

  task automatic run_b(input vec12_t v, output logic [11:0] c0,
                       output logic [11:0] c1, output int n,
                       output logic dn);
    logic [7:0] arr[3];
    int         bi;
    logic       tk, hs;
    arr[0] = v.b0;
    arr[1] = v.b1;
    arr[2] = v.b2;
    bi = 0;
    n  = 0;
    c0 = '0;
    c1 = '0;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
      in_valid_b  = (bi < 3);
      in_byte_b   = (bi < 3) ? arr[bi] : 8'h00;
      out_ready_b = 1'b1;
      tk = in_valid_b && in_ready_b;
      hs = out_valid_b;
      if (out_valid_b && in_ready_b) overlap_b++;
      if (hs && n == 0) c0 = out_coeff_b;
      if (hs && n == 1) c1 = out_coeff_b;
      @(posedge clk); #1;
      if (tk) bi++;
      if (hs) n++;
    end
    dn = done_b;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
  endtask

  logic [7:0]  bc[2];
  logic        expc[16];
  logic        gc[16];
  logic [11:0] r0, r1;
  logic        rdn, irs, a1, h1;
  int          n, mism, bi_c, n_c, dcnt;

  initial begin
    v12[0] = '{8'h01, 8'h23, 8'h45, 12'h301, 12'h452};
    v12[1] = '{8'hFF, 8'h00, 8'hFF, 12'h0FF, 12'hFF0};
    v12[2] = '{8'h00, 8'hF0, 8'h0F, 12'h000, 12'h0FF};
    v12[3] = '{8'hAB, 8'hCD, 8'hEF, 12'hDAB, 12'hEFC};
    v12[4] = '{8'h12, 8'h34, 8'h56, 12'h412, 12'h563};
    for (int k = 0; k < 256; k++) bytes_a[k] = 8'(k * 37 + 5);
    bytes_a[0]  = 8'h49;
    bytes_a[1]  = 8'h8B;
    bytes_a[2]  = 8'h0B;
    bytes_a[3]  = 8'hFF;
    bytes_a[31] = 8'hA4;
    bc[0] = 8'h49;
    bc[1] = 8'hB6;
    expc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    {start_a, abort_a, in_valid_a, out_ready_a} = '0;
    {start_b, abort_b, in_valid_b, out_ready_b} = '0;
    {start_c, abort_c, in_valid_c, out_ready_c} = '0;
    in_byte_a = '0;
    in_byte_b = '0;
    in_byte_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {busy_a, done_a, in_ready_a, out_valid_a,
                    out_coeff_a, out_index_a}, 32'h0);
    rst_n = 1'b1;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready_a, 1'b0);
    in_valid_a = 1'b0;

    // ELL=8 full decode without stalls
    pulse_start_a();
    chk("t1_busy", busy_a, 1'b1);
    feed_a(256, 256, n);
    chk("t1_count", n, 256);
    chk("t1_c0", got_a[0], 73);
    chk("t1_c1", got_a[1], 139);
    chk("t1_c2", got_a[2], 11);
    chk("t1_c3", got_a[3], 255);
    chk("t1_c31", got_a[31], 164);
    mism = 0;
    for (int k = 0; k < 256; k++)
      if (got_a[k] !== bytes_a[k] || gidx_a[k] !== 8'(k)) mism++;
    chk("t1_all", mism, 0);
    chk("t1_done", done_a, 1'b1);
    chk("t1_overlap", overlap_a, 0);
    @(posedge clk); #1;
    chk("t1_idle", {done_a, busy_a}, 2'b00);

    // back-pressure, ignored start, then abort on a handshake
    pulse_start_a();
    in_valid_a  = 1'b1;
    in_byte_a   = 8'h5A;
    out_ready_a = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_byte_a = 8'hEE;
      start_a   = (i == 2);
      chk("t4_stall", {out_valid_a, in_ready_a, busy_a, out_coeff_a,
                       out_index_a}, {1'b1, 1'b0, 1'b1, 8'h5A, 8'h00});
      @(posedge clk); #1;
    end
    start_a     = 1'b0;
    in_byte_a   = 8'h3C;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    chk("t4_after", {in_ready_a, out_valid_a, out_index_a},
        {1'b1, 1'b0, 8'd1});
    out_ready_a = 1'b0;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    chk("t4_next", {out_valid_a, out_coeff_a, out_index_a},
        {1'b1, 8'h3C, 8'd1});
    out_ready_a = 1'b1;
    abort_a     = 1'b1;
    @(posedge clk); #1;
    abort_a     = 1'b0;
    out_ready_a = 1'b0;
    chk("t6_abort", {busy_a, out_valid_a, done_a, out_index_a}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_a) dcnt++;
      @(posedge clk); #1;
    end
    chk("t6_no_done", dcnt, 0);

    // async reset mid-decode
    pulse_start_a();
    feed_a(256, 10, n);
    chk("t5_count", n, 10);
    chk("t5_c9", {got_a[9], gidx_a[9]}, {bytes_a[9], 8'd9});
    chk("t5_busy", {busy_a, out_index_a}, {1'b1, 8'd10});
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_reset", {busy_a, done_a, in_ready_a, out_valid_a,
                     out_coeff_a, out_index_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", busy_a, 1'b0);
    pulse_start_a();
    feed_a(256, 1, n);
    chk("t5_restart", {got_a[0], gidx_a[0]}, {8'h49, 8'd0});
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;

    // ELL=12 vector table
    for (int i = 0; i < 5; i++) begin
      run_b(v12[i], r0, r1, n, rdn);
      chk("t2_n", n, 2);
      chk("t2_c0", r0, v12[i].c0);
      chk("t2_c1", r1, v12[i].c1);
      chk("t2_done", rdn, 1'b1);
    end
    chk("t2_overlap", overlap_b, 0);

    // ELL=1 bit-serial
    @(posedge clk); #1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    bi_c = 0;
    n_c  = 0;
    irs  = 1'b0;
    for (int cyc = 0; cyc < 80 && n_c < 16; cyc++) begin
      in_valid_c  = (bi_c < 2);
      in_byte_c   = (bi_c < 2) ? bc[bi_c] : 8'h00;
      out_ready_c = 1'b1;
      a1 = in_valid_c && in_ready_c;
      h1 = out_valid_c;
      if (h1) gc[n_c] = out_coeff_c[0];
      if (n_c == 8 && bi_c == 1 && in_ready_c) irs = 1'b1;
      @(posedge clk); #1;
      if (a1) bi_c++;
      if (h1) n_c++;
    end
    in_valid_c  = 1'b0;
    out_ready_c = 1'b0;
    chk("t3_count", n_c, 16);
    for (int k = 0; k < 16; k++) chk("t3_bit", gc[k], expc[k]);
    chk("t3_in_ready", irs, 1'b1);
    chk("t3_done", done_c, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
